// File: rtl/byte_serial_add32_ctrl.sv
// byte_serial_add32_ctrl
// 32-bit add (optionally subtract) built from four passes through one shared,
// external 8-bit adder. An operation latches its operands, then spends four
// RUN cycles on bytes 0..3 (carry threaded through a register), raises done
// for one cycle and returns to IDLE.
//
// Optional feature: define ADD32_SUB_EN to add the op_sub port. When op_sub is
// latched high, b is inverted and the initial carry is 1, giving a - b
// (cout=1 then means "no borrow").
module byte_serial_add32_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
`ifdef ADD32_SUB_EN
    input  logic        op_sub,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        cout,
    output logic        ovf,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_cin,
    input  logic [7:0]  add_sum,
    input  logic        add_cout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [1:0]  r_idx;
    logic [31:0] r_a;
    logic [31:0] r_b;        // effective b (already inverted for subtract)
    logic        r_carry;
    logic [31:0] r_result;
    logic        r_cout;
    logic        r_ovf;

    logic        w_accept;
    logic        w_last;
    logic        w_cin0;
    logic [31:0] w_b_eff;
    logic        w_ovf;

    // A start only counts while idle; RUN and DONE ignore it entirely.
    assign w_accept = (r_state == S_IDLE) && start;
    assign w_last   = (r_idx == 2'd3);

`ifdef ADD32_SUB_EN
    logic r_sub;

    // Latch the subtract select together with the operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sub <= 1'b0;
        end else if (w_accept) begin
            r_sub <= op_sub;
        end
    end

    assign w_b_eff = op_sub ? ~op_b : op_b;
    assign w_cin0  = r_sub;
`else
    assign w_b_eff = op_b;
    assign w_cin0  = 1'b0;
`endif

    // Signed overflow: operands agree in sign but the top result bit does not.
    // Evaluated on the byte-3 capture, where add_sum[7] becomes result[31].
    assign w_ovf = (r_a[31] == r_b[31]) && (add_sum[7] != r_a[31]);

    // State register; reset wins over everything, including a same-cycle start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic: IDLE -> RUN on start, RUN -> DONE after byte 3,
    // DONE -> IDLE unconditionally.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded from state; the shared adder sees zeros outside RUN.
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        add_a   = 8'd0;
        add_b   = 8'd0;
        add_cin = 1'b0;
        case (r_state)
            S_RUN: begin
                busy    = 1'b1;
                add_a   = r_a[8*r_idx +: 8];
                add_b   = r_b[8*r_idx +: 8];
                add_cin = (r_idx == 2'd0) ? w_cin0 : r_carry;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand latch: captured only on an accepted start, held afterwards.
    always_ff @(posedge clk) begin
        if (w_accept && !rst) begin
            r_a <= op_a;
            r_b <= w_b_eff;
        end
    end

    // Byte-serial datapath: each RUN cycle stores one sum byte and the carry;
    // the last byte also freezes cout/ovf, which then hold until the next start.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx    <= 2'd0;
            r_carry  <= 1'b0;
            r_result <= 32'd0;
            r_cout   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_idx    <= 2'd0;
            r_carry  <= 1'b0;
            r_result <= 32'd0;
        end else if (r_state == S_RUN) begin
            r_result[8*r_idx +: 8] <= add_sum;
            r_carry                <= add_cout;
            r_idx                  <= r_idx + 2'd1;
            if (w_last) begin
                r_cout <= add_cout;
                r_ovf  <= w_ovf;
            end
        end
    end

    assign result = r_result;
    assign cout   = r_cout;
    assign ovf    = r_ovf;

endmodule
